idli_sqi_mem_m: RTL and testbench

- Synthesisable SQI serial-SRAM responder, the device end of the quad-SPI link driven by idli_sqi_m.
- Decodes command, address and dummy phases from the controller's SCK/CS/SIO, then streams read nibbles back or absorbs write nibbles into an internal byte RAM.
- Used as the memory behind each SQI lane in simulation and FPGA builds; one instance per lane, SQI_NUM instances total.

---
 rtl/idli_pkg.sv | 19 +
 rtl/idli_sqi_mem_ram_m.sv | 22 ++
 rtl/idli_sqi_mem_m.sv | 167 ++++++++++++++++
 tb/tb_idli_sqi_mem_m.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/idli_pkg.sv
// Shared types and constants for the idli SQI link.
package idli_pkg;

  typedef logic [3:0] sqi_data_t;

  localparam logic [7:0] SQI_CMD_READ  = 8'h03;
  localparam logic [7:0] SQI_CMD_WRITE = 8'h02;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    RD_DATA,
    WR_DATA,
    IGNORE
  } sqi_mem_state_t;

endpackage

// File: rtl/idli_sqi_mem_ram_m.sv
// Byte RAM behind one SQI lane: one write port, one registered read port.
module idli_sqi_mem_ram_m #(
  parameter int ADDR_W = 17
) (
  input  logic              gck,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem [2**ADDR_W];

  // NOTE: storage has no reset so it maps onto block RAM; only control state is reset.
  always_ff @(posedge gck) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/idli_sqi_mem_m.sv
// SQI serial-SRAM responder: decodes cmd/addr/dummy nibbles and serves reads/writes.
module idli_sqi_mem_m
  import idli_pkg::*;
#(
  parameter int ADDR_W    = 17,
  parameter int ADDR_NIB  = 6,
  parameter int DUMMY_NIB = 2
) (
  input  logic      i_mem_gck,
  input  logic      i_mem_rst,
  input  logic      i_mem_sck,
  input  logic      i_mem_cs,
  input  sqi_data_t i_mem_sio,
  output sqi_data_t o_mem_sio,
  output logic      o_mem_sio_oe
);

  localparam int CNT_MAX = (ADDR_NIB > DUMMY_NIB) ? ADDR_NIB : DUMMY_NIB;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  sqi_mem_state_t    state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [ADDR_W-1:0] addr, addr_d, addr_inc, addr_shift;
  sqi_data_t         nib, nib_d;
  logic              half, half_d;
  logic              is_wr, is_wr_d;
  sqi_data_t         sio_d;
  logic              oe_d;

  logic              rd_en, wr_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;

  logic xfer;
  assign xfer       = i_mem_sck & ~i_mem_cs;
  assign addr_inc   = addr + ADDR_W'(1);
  // The wire address is wider than the RAM; shifting within ADDR_W keeps only its low bits.
  assign addr_shift = {addr[ADDR_W-5:0], i_mem_sio};

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    addr_d  = addr;
    nib_d   = nib;
    half_d  = half;
    is_wr_d = is_wr;
    sio_d   = o_mem_sio;
    oe_d    = o_mem_sio_oe;
    rd_en   = 1'b0;
    rd_addr = addr;
    wr_en   = 1'b0;

    if (i_mem_cs) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      sio_d   = '0;
      half_d  = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          state_d = CMD;
          cnt_d   = '0;
          half_d  = 1'b0;
        end
        CMD: if (xfer) begin
          if (cnt == '0) begin
            nib_d = i_mem_sio;
            cnt_d = CNT_W'(1);
          end else begin
            cnt_d = '0;
            case ({nib, i_mem_sio})
              SQI_CMD_READ:  begin is_wr_d = 1'b0; state_d = ADDR; end
              SQI_CMD_WRITE: begin is_wr_d = 1'b1; state_d = ADDR; end
              default:       state_d = IGNORE;
            endcase
          end
        end
        ADDR: if (xfer) begin
          addr_d = addr_shift;
          if (cnt == CNT_W'(ADDR_NIB - 1)) begin
            cnt_d = '0;
            if (is_wr) begin
              state_d = WR_DATA;
            end else begin
              state_d = DUMMY;
              rd_en   = 1'b1;
              rd_addr = addr_shift;
            end
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
        DUMMY: if (xfer) begin
          if (cnt == CNT_W'(DUMMY_NIB - 1)) begin
            state_d = RD_DATA;
            cnt_d   = '0;
            oe_d    = 1'b1;
            sio_d   = rd_data[7:4];
            half_d  = 1'b0;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
        RD_DATA: if (xfer) begin
          // Prefetch the next byte while the low nibble of this one goes out.
          if (!half) begin
            sio_d   = rd_data[3:0];
            rd_en   = 1'b1;
            rd_addr = addr_inc;
            addr_d  = addr_inc;
            half_d  = 1'b1;
          end else begin
            sio_d  = rd_data[7:4];
            half_d = 1'b0;
          end
        end
        WR_DATA: if (xfer) begin
          if (!half) begin
            nib_d  = i_mem_sio;
            half_d = 1'b1;
          end else begin
            wr_en  = 1'b1;
            addr_d = addr_inc;
            half_d = 1'b0;
          end
        end
        IGNORE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge i_mem_gck) begin
    if (i_mem_rst) begin
      state        <= IDLE;
      cnt          <= '0;
      addr         <= '0;
      nib          <= '0;
      half         <= 1'b0;
      is_wr        <= 1'b0;
      o_mem_sio    <= '0;
      o_mem_sio_oe <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      addr         <= addr_d;
      nib          <= nib_d;
      half         <= half_d;
      is_wr        <= is_wr_d;
      o_mem_sio    <= sio_d;
      o_mem_sio_oe <= oe_d;
    end
  end

  idli_sqi_mem_ram_m #(.ADDR_W(ADDR_W)) u_ram (
    .gck     (i_mem_gck),
    .wr_en   (wr_en & ~i_mem_rst),
    .wr_addr (addr),
    .wr_data ({nib, i_mem_sio}),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_idli_sqi_mem_m.sv
// Directed bench for the SQI memory responder: write/read, wrap, spacing, aborts.
module tb_idli_sqi_mem_m;
  import idli_pkg::*;

  logic      gck = 1'b0;
  logic      rst, sck, cs;
  sqi_data_t sio_in, sio_out;
  logic      oe;

  int errors = 0;
  int checks = 0;
  int gap    = 0;

  always #5 gck = ~gck;

  idli_sqi_mem_m dut (
    .i_mem_gck    (gck),
    .i_mem_rst    (rst),
    .i_mem_sck    (sck),
    .i_mem_cs     (cs),
    .i_mem_sio    (sio_in),
    .o_mem_sio    (sio_out),
    .o_mem_sio_oe (oe)
  );

  task automatic tick();
    @(posedge gck);
    #1;
  endtask

  task automatic send_nib(input logic [3:0] n);
    sio_in = n;
    sck    = 1'b1;
    tick();
    sck    = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] a);
    send_nib(cmd[7:4]);
    send_nib(cmd[3:0]);
    for (int i = 5; i >= 0; i--) send_nib(a[i*4 +: 4]);
  endtask

  task automatic cs_begin();
    cs  = 1'b0;
    sck = 1'b0;
    tick();
  endtask

  task automatic cs_end(input string name);
    sck = 1'b0;
    tick();
    cs = 1'b1;
    tick();
    checks++;
    if (oe !== 1'b0) begin
      errors++;
      $display("FAIL %s cs_oe: got %b expected 0", name, oe);
    end
  endtask

  task automatic do_write(input logic [23:0] a, input int n_nib, input logic [31:0] data);
    cs_begin();
    send_hdr(SQI_CMD_WRITE, a);
    for (int i = 0; i < n_nib; i++) send_nib(data[(n_nib-1-i)*4 +: 4]);
    cs_end("write");
  endtask

  task automatic do_read(input logic [23:0] a, input int n_nib, input logic [31:0] exp,
                         input string name);
    logic [3:0] e;
    cs_begin();
    send_hdr(SQI_CMD_READ, a);
    send_nib(4'h0);
    checks++;
    if (oe !== 1'b0) begin
      errors++;
      $display("FAIL %s oe_early: got %b expected 0", name, oe);
    end
    sio_in = 4'h0;
    sck    = 1'b1;
    tick();
    sck    = 1'b0;
    for (int i = 0; i < n_nib; i++) begin
      e = exp[(n_nib-1-i)*4 +: 4];
      checks++;
      if (oe !== 1'b1 || sio_out !== e) begin
        errors++;
        $display("FAIL %s nib%0d: got oe=%b sio=%h expected oe=1 sio=%h", name, i, oe, sio_out, e);
      end
      if (i < n_nib - 1) begin
        e      = exp[(n_nib-2-i)*4 +: 4];
        sio_in = 4'h0;
        sck    = 1'b1;
        tick();
        sck    = 1'b0;
        for (int g = 0; g < gap; g++) begin
          checks++;
          if (sio_out !== e) begin
            errors++;
            $display("FAIL %s hold%0d_%0d: got %h expected %h", name, i, g, sio_out, e);
          end
          tick();
        end
      end
    end
    cs_end(name);
  endtask

  task automatic test_reset();
    rst = 1'b1; cs = 1'b1; sck = 1'b0; sio_in = 4'h0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checks++;
    if (oe !== 1'b0 || sio_out !== 4'h0 || dut.state !== IDLE) begin
      errors++;
      $display("FAIL reset: got oe=%b sio=%h state=%0d expected 0 0 IDLE", oe, sio_out, dut.state);
    end
    cs = 1'b0;
    repeat (10) tick();
    checks++;
    if (oe !== 1'b0 || sio_out !== 4'h0 || dut.state !== CMD) begin
      errors++;
      $display("FAIL cs_no_sck: got oe=%b sio=%h state=%0d expected 0 0 CMD", oe, sio_out, dut.state);
    end
    cs_end("cs_no_sck");
  endtask

  task automatic test_write_read();
    do_write(24'h000010, 4, 32'h0000A53C);
    do_read(24'h000010, 4, 32'h0000A53C, "rd_b2b");
  endtask

  task automatic test_wrap();
    do_write(24'h01FFFF, 4, 32'h0000FF11);
    do_read(24'h01FFFF, 4, 32'h0000FF11, "rd_wrap");
    do_read(24'h000000, 2, 32'h00000011, "rd_zero");
  endtask

  task automatic test_spaced_read();
    gap = 2;
    do_read(24'h000010, 4, 32'h0000A53C, "rd_spaced");
    gap = 0;
  endtask

  task automatic test_partial_write();
    do_write(24'h000020, 2, 32'h0000005A);
    do_write(24'h000020, 1, 32'h00000007);
    do_read(24'h000020, 2, 32'h0000005A, "rd_partial");
  endtask

  task automatic test_ignore();
    logic seen_oe;
    seen_oe = 1'b0;
    cs_begin();
    send_nib(4'h9);
    send_nib(4'hF);
    for (int i = 0; i < 20; i++) begin
      send_nib(4'(i));
      if (oe !== 1'b0) seen_oe = 1'b1;
    end
    checks++;
    if (seen_oe !== 1'b0 || dut.state !== IGNORE) begin
      errors++;
      $display("FAIL ignore: got oe_seen=%b state=%0d expected 0 IGNORE", seen_oe, dut.state);
    end
    cs_end("ignore");
    do_read(24'h000010, 4, 32'h0000A53C, "rd_after_ignore");
  endtask

  task automatic test_reset_mid_read();
    cs_begin();
    send_hdr(SQI_CMD_READ, 24'h000010);
    send_nib(4'h0);
    send_nib(4'h0);
    checks++;
    if (oe !== 1'b1 || sio_out !== 4'hA) begin
      errors++;
      $display("FAIL mid_read_pre: got oe=%b sio=%h expected 1 a", oe, sio_out);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (oe !== 1'b0 || sio_out !== 4'h0 || dut.state !== IDLE) begin
      errors++;
      $display("FAIL mid_read_rst: got oe=%b sio=%h state=%0d expected 0 0 IDLE", oe, sio_out, dut.state);
    end
    rst = 1'b0;
    cs  = 1'b1;
    tick();
    do_read(24'h000010, 4, 32'h0000A53C, "rd_after_rst");
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_wrap();
    test_spaced_read();
    test_partial_write();
    test_ignore();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
